// File: rtl/sign_mag_to_bcd_pkg.sv
// Shared constants and state encoding for the sign/magnitude to BCD converter.
package sign_mag_to_bcd_pkg;

    // Default magnitude width and number of BCD digits (10^3 > 2^8 - 1).
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    // Width of one BCD digit.
    localparam int NIBBLE_W   = 4;

    // Converter control states; the finish pulse is a flag, not a state.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sign_mag_to_bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next BCD digit.
// Codes 10..15 never occur in a valid flow; they simply wrap modulo 16.
module bcd_add3
    import sign_mag_to_bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nib,
    output logic [NIBBLE_W-1:0] o_nib
);

    // Conditional +3 adjust of one BCD digit.
    always_comb begin
        o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
    end

endmodule

// File: rtl/sign_mag_to_bcd.sv
// Sequential sign/magnitude to BCD converter (shift-add-3, one bit per clock).
// A single-cycle bcd_sel starts (or restarts) a conversion; sign/bcd update
// together with a one-cycle bcd_finish pulse WIDTH clocks after the start.
module sign_mag_to_bcd
    import sign_mag_to_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bcd_sel,
    input  logic                       sign_in,
    input  logic [WIDTH-1:0]           mag_in,
    output logic                       sign,
    output logic [NIBBLE_W*DIGITS-1:0] bcd,
    output logic                       busy,
    output logic                       bcd_finish
);

    localparam int BCD_W = NIBBLE_W * DIGITS;
    localparam int SH_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Shift register layout: [SH_W-1:WIDTH] BCD digits, [WIDTH-1:0] binary.
    state_t             r_state,    w_state_nxt;
    logic [SH_W-1:0]    r_shift,    w_shift_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic               r_sign_lat, w_sign_lat_nxt;
    logic               r_sign,     w_sign_nxt;
    logic [BCD_W-1:0]   r_bcd,      w_bcd_nxt;
    logic               r_finish,   w_finish_nxt;

    logic [SH_W-1:0]    w_adj;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last;

    // One correction cell per BCD digit, applied before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_shift[WIDTH + g*NIBBLE_W +: NIBBLE_W]),
            .o_nib (w_adj  [WIDTH + g*NIBBLE_W +: NIBBLE_W])
        );
    end

    assign w_adj[WIDTH-1:0] = r_shift[WIDTH-1:0];
    assign w_cnt_inc        = r_cnt + 1'b1;
    assign w_last           = (w_cnt_inc == CNT_W'(WIDTH));

    // Next-state and datapath: restart has priority over shifting/completion.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold it.
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_sign_lat_nxt = r_sign_lat;
        w_sign_nxt     = r_sign;
        w_bcd_nxt      = r_bcd;
        w_finish_nxt   = 1'b0;

        if (bcd_sel) begin
            w_state_nxt    = ST_SHIFT;
            w_shift_nxt    = {{BCD_W{1'b0}}, mag_in};
            w_cnt_nxt      = '0;
            w_sign_lat_nxt = sign_in;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    w_shift_nxt = {w_adj[SH_W-2:0], 1'b0};
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_last) begin
                        // Upper BCD_W bits of the post-shift value.
                        w_bcd_nxt    = w_adj[SH_W-2 -: BCD_W];
                        w_sign_nxt   = r_sign_lat;
                        w_finish_nxt = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_sign_lat <= 1'b0;
            r_sign     <= 1'b0;
            r_bcd      <= '0;
            r_finish   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update from
            // the same pre-edge values, matching real flip-flop behaviour.
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sign_lat <= w_sign_lat_nxt;
            r_sign     <= w_sign_nxt;
            r_bcd      <= w_bcd_nxt;
            r_finish   <= w_finish_nxt;
        end
    end

    assign sign       = r_sign;
    assign bcd        = r_bcd;
    assign busy       = (r_state == ST_SHIFT);
    assign bcd_finish = r_finish;

endmodule
